// File: rtl/microwave_timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : microwave_pkg
// Purpose  : Shared types and constants for the microwave cook timer.
//            Holds the controller state enum, the BCD digit type and the
//            per-digit upper limits used for time entry and countdown.
// Revision : 1.0 - initial release
// ============================================================================
package microwave_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam bcd_digit_t MAX_MINUTES = 4'd9;
  localparam bcd_digit_t MAX_TENS    = 4'd5;
  localparam bcd_digit_t MAX_UNITS   = 4'd9;

endpackage : microwave_pkg
`default_nettype wire

// File: rtl/microwave_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : microwave_timer_ctrl_if
// Purpose  : Front-panel bundle of the microwave timer controller.
// Ports    : keypad_valid/keypad_digit, start, stop_clear, door_closed
//            (panel -> controller); minutes, second_tens, second_units,
//            mag_on, done, alarm (controller -> panel/decoder/magnetron).
//            master = panel side, slave = controller side.
// Revision : 1.0 - initial release
// ============================================================================
interface microwave_timer_ctrl_if;
  import microwave_pkg::*;

  logic       keypad_valid;
  bcd_digit_t keypad_digit;
  logic       start;
  logic       stop_clear;
  logic       door_closed;
  bcd_digit_t minutes;
  bcd_digit_t second_tens;
  bcd_digit_t second_units;
  logic       mag_on;
  logic       done;
  logic       alarm;

  modport master (
    output keypad_valid, keypad_digit, start, stop_clear, door_closed,
    input  minutes, second_tens, second_units, mag_on, done, alarm
  );

  modport slave (
    input  keypad_valid, keypad_digit, start, stop_clear, door_closed,
    output minutes, second_tens, second_units, mag_on, done, alarm
  );

endinterface : microwave_timer_ctrl_if
`default_nettype wire

// File: rtl/microwave_timer_ctrl_bcd_time_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_time_counter
// Purpose  : Three-digit BCD time register (M:TU) with key shift-in,
//            one-second decrement and clear.
// Ports    : clk, reset (async, active high)
//            i_clear    - zero all digits (highest priority)
//            i_dec      - subtract one second with BCD borrows
//            i_shift_in - shift i_key in from the right
//            i_key      - BCD key value for shift-in
//            o_minutes, o_tens, o_units - registered digits
//            o_is_zero  - time reads 0:00
// Revision : 1.0 - initial release
// ============================================================================
module bcd_time_counter
  import microwave_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_dec,
  input  logic       i_shift_in,
  input  bcd_digit_t i_key,
  output bcd_digit_t o_minutes,
  output bcd_digit_t o_tens,
  output bcd_digit_t o_units,
  output logic       o_is_zero
);

  bcd_digit_t r_minutes;
  bcd_digit_t r_tens;
  bcd_digit_t r_units;
  logic       w_is_zero;
  logic       w_key_ok;

  assign w_is_zero = (r_minutes == 4'd0) && (r_tens == 4'd0) && (r_units == 4'd0);

  // The current units digit becomes the tens digit, so it must already be a
  // legal tens value; this keeps the displayed time always valid.
  assign w_key_ok = (i_key <= MAX_UNITS) && (r_units <= MAX_TENS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_minutes <= 4'd0;
      r_tens    <= 4'd0;
      r_units   <= 4'd0;
    end else if (i_clear) begin
      r_minutes <= 4'd0;
      r_tens    <= 4'd0;
      r_units   <= 4'd0;
    end else if (i_dec && !w_is_zero) begin
      if (r_units != 4'd0) begin
        r_units <= r_units - 4'd1;
      end else begin
        r_units <= MAX_UNITS;
        if (r_tens != 4'd0) begin
          r_tens <= r_tens - 4'd1;
        end else begin
          r_tens    <= MAX_TENS;
          r_minutes <= r_minutes - 4'd1;
        end
      end
    end else if (i_shift_in && w_key_ok) begin
      r_minutes <= r_tens;
      r_tens    <= r_units;
      r_units   <= i_key;
    end
  end

  assign o_minutes = r_minutes;
  assign o_tens    = r_tens;
  assign o_units   = r_units;
  assign o_is_zero = w_is_zero;

endmodule : bcd_time_counter
`default_nettype wire

// File: rtl/microwave_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : microwave_timer_ctrl
// Purpose  : Cook-timer sequencer: keypad time entry, once-per-second
//            countdown while cooking, door-open pause, stop/clear and
//            completion handling. Optional macro DONE_ALARM_EN makes DONE
//            persistent with a timed alarm; without it DONE is a one-cycle
//            pulse and alarm is tied low.
// Ports    : clk, reset (async, active high), io_bus (slave modport of
//            microwave_timer_ctrl_if carrying panel inputs and the digit,
//            mag_on, done, alarm outputs).
// Params   : TICKS_PER_SEC (>= 2) clocks per second, ALARM_SECS alarm length.
// Revision : 1.0 - initial release
// ============================================================================
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int ALARM_SECS    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  microwave_timer_ctrl_if.slave io_bus
);

  localparam int c_PRESC_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [c_PRESC_W-1:0] c_TICK_MAX = c_PRESC_W'(TICKS_PER_SEC - 1);

  timer_state_t         r_state;
  timer_state_t         w_state_nxt;
  logic [c_PRESC_W-1:0] r_presc;
  logic [c_PRESC_W-1:0] w_presc_nxt;
  logic                 w_tick;
  logic                 w_clear;
  logic                 w_dec;
  logic                 w_shift;
  logic                 w_is_zero;
  logic                 w_is_one;
  logic                 r_mag_on;
  logic                 r_done;
  bcd_digit_t           w_minutes;
  bcd_digit_t           w_tens;
  bcd_digit_t           w_units;

`ifdef DONE_ALARM_EN
  localparam int c_ACNT_W = $clog2(ALARM_SECS + 1);
  localparam logic [c_ACNT_W-1:0] c_ACNT_MAX = c_ACNT_W'(ALARM_SECS);
  logic [c_ACNT_W-1:0] r_acnt;
  logic [c_ACNT_W-1:0] w_acnt_nxt;
  logic                r_alarm;
`endif

  bcd_time_counter u_time (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_dec      (w_dec),
    .i_shift_in (w_shift),
    .i_key      (io_bus.keypad_digit),
    .o_minutes  (w_minutes),
    .o_tens     (w_tens),
    .o_units    (w_units),
    .o_is_zero  (w_is_zero)
  );

  assign w_tick = (r_presc == c_TICK_MAX);

  // Lets the last decrement enter DONE on the same edge that shows 0:00.
  assign w_is_one = (w_minutes == 4'd0) && (w_tens == 4'd0) && (w_units == 4'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_presc  <= '0;
      r_mag_on <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_presc  <= w_presc_nxt;
      r_mag_on <= (w_state_nxt == COOK);
      r_done   <= (w_state_nxt == DONE);
    end
  end

`ifdef DONE_ALARM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acnt  <= '0;
      r_alarm <= 1'b0;
    end else begin
      r_acnt  <= w_acnt_nxt;
      r_alarm <= (w_state_nxt == DONE) && (w_acnt_nxt < c_ACNT_MAX);
    end
  end
`endif

  // Branch order inside each state encodes the priority
  // stop_clear > door open > start > prescaler tick > keypad.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_clear     = 1'b0;
    w_dec       = 1'b0;
    w_shift     = 1'b0;
`ifdef DONE_ALARM_EN
    w_acnt_nxt  = r_acnt;
`endif
    case (r_state)
      IDLE: begin
        if (io_bus.stop_clear) begin
          w_clear = 1'b1;
        end else if (io_bus.start && io_bus.door_closed && !w_is_zero) begin
          w_state_nxt = COOK;
          w_presc_nxt = '0;
        end else if (io_bus.keypad_valid) begin
          w_shift = 1'b1;
        end
      end
      COOK: begin
        if (io_bus.stop_clear || !io_bus.door_closed) begin
          // Prescaler is frozen so resuming continues the partial second.
          w_state_nxt = PAUSE;
        end else if (w_tick) begin
          w_presc_nxt = '0;
          w_dec       = 1'b1;
          if (w_is_one) begin
            w_state_nxt = DONE;
`ifdef DONE_ALARM_EN
            w_acnt_nxt  = '0;
`endif
          end
        end else begin
          w_presc_nxt = r_presc + c_PRESC_W'(1);
        end
      end
      PAUSE: begin
        if (io_bus.stop_clear) begin
          w_state_nxt = IDLE;
          w_clear     = 1'b1;
          w_presc_nxt = '0;
        end else if (io_bus.start && io_bus.door_closed) begin
          w_state_nxt = COOK;
        end
      end
      DONE: begin
`ifdef DONE_ALARM_EN
        if (io_bus.stop_clear || !io_bus.door_closed) begin
          w_state_nxt = IDLE;
          w_clear     = 1'b1;
          w_presc_nxt = '0;
        end else if (r_acnt < c_ACNT_MAX) begin
          // The prescaler is reused to time the alarm in whole seconds.
          if (w_tick) begin
            w_presc_nxt = '0;
            w_acnt_nxt  = r_acnt + c_ACNT_W'(1);
          end else begin
            w_presc_nxt = r_presc + c_PRESC_W'(1);
          end
        end
`else
        w_state_nxt = IDLE;
        w_presc_nxt = '0;
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign io_bus.minutes      = w_minutes;
  assign io_bus.second_tens  = w_tens;
  assign io_bus.second_units = w_units;
  assign io_bus.mag_on       = r_mag_on;
  assign io_bus.done         = r_done;
`ifdef DONE_ALARM_EN
  assign io_bus.alarm        = r_alarm;
`else
  assign io_bus.alarm        = 1'b0;
`endif

endmodule : microwave_timer_ctrl
`default_nettype wire

// File: tb/tb_microwave_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_microwave_timer_ctrl
// Purpose  : Self-checking bench for microwave_timer_ctrl with
//            TICKS_PER_SEC = 4, ALARM_SECS = 3. The reference model keeps the
//            cook time as a plain count of seconds. Honours DONE_ALARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_microwave_timer_ctrl;

  localparam int T = 4;
  localparam int A = 3;

  localparam int S_IDLE  = 0;
  localparam int S_COOK  = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  microwave_timer_ctrl_if bus ();

  microwave_timer_ctrl #(
    .TICKS_PER_SEC (T),
    .ALARM_SECS    (A)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_state = S_IDLE;
  int m_secs  = 0;
  int m_presc = 0;
  int m_acnt  = 0;

  logic [14:0] dut_vec;
  assign dut_vec = {bus.minutes, bus.second_tens, bus.second_units,
                    bus.mag_on, bus.done, bus.alarm};

  function automatic logic [14:0] model_vec();
    logic [3:0] mm, tt, uu;
    logic       al;
    mm = 4'(m_secs / 60);
    tt = 4'((m_secs % 60) / 10);
    uu = 4'(m_secs % 10);
`ifdef DONE_ALARM_EN
    al = (m_state == S_DONE) && (m_acnt < A);
`else
    al = 1'b0;
`endif
    return {mm, tt, uu, (m_state == S_COOK), (m_state == S_DONE), al};
  endfunction

  function automatic logic [11:0] bcd3(input int m, input int t, input int u);
    return {4'(m), 4'(t), 4'(u)};
  endfunction

  task automatic model_reset();
    m_state = S_IDLE;
    m_secs  = 0;
    m_presc = 0;
    m_acnt  = 0;
  endtask

  task automatic model_step(input logic kv, input int kd, input logic st,
                            input logic sc, input logic dc);
    case (m_state)
      S_IDLE: begin
        if (sc) m_secs = 0;
        else if (st && dc && m_secs > 0) begin
          m_state = S_COOK;
          m_presc = 0;
        end else if (kv && kd <= 9 && (m_secs % 10) <= 5)
          m_secs = ((m_secs % 60) / 10) * 60 + (m_secs % 10) * 10 + kd;
      end
      S_COOK: begin
        if (sc || !dc) m_state = S_PAUSE;
        else if (m_presc == T - 1) begin
          m_presc = 0;
          m_secs  = m_secs - 1;
          if (m_secs == 0) begin
            m_state = S_DONE;
            m_acnt  = 0;
          end
        end else m_presc = m_presc + 1;
      end
      S_PAUSE: begin
        if (sc) begin
          m_state = S_IDLE;
          m_secs  = 0;
          m_presc = 0;
        end else if (st && dc) m_state = S_COOK;
      end
      default: begin
`ifdef DONE_ALARM_EN
        if (sc || !dc) begin
          m_state = S_IDLE;
          m_presc = 0;
        end else if (m_acnt < A) begin
          if (m_presc == T - 1) begin
            m_presc = 0;
            m_acnt  = m_acnt + 1;
          end else m_presc = m_presc + 1;
        end
`else
        m_state = S_IDLE;
        m_presc = 0;
`endif
      end
    endcase
  endtask

  // Drive one cycle of inputs, advance the model on the edge, sample at +1.
  task automatic cycle(input logic kv, input int kd, input logic st,
                       input logic sc, input logic dc);
    bus.keypad_valid = kv;
    bus.keypad_digit = 4'(kd);
    bus.start        = st;
    bus.stop_clear   = sc;
    bus.door_closed  = dc;
    @(posedge clk);
    model_step(kv, kd, st, sc, dc);
    #1;
    bus.keypad_valid = 1'b0;
  endtask

  task automatic press(input int d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    bus.keypad_valid = 1'b0;
    bus.keypad_digit = 4'd0;
    bus.start        = 1'b0;
    bus.stop_clear   = 1'b0;
    bus.door_closed  = 1'b1;
    reset = 1'b1;
    #12;
    n_tests++;
    if (dut_vec !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", dut_vec, 15'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle_cycles(1);
    n_tests++;
    if (dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_keypad_entry();
    press(1); press(3); press(0);
    n_tests++;
    if (dut_vec[14:3] !== bcd3(1, 3, 0)) begin
      n_fail++;
      $display("FAIL key_130: got %h expected %h", dut_vec[14:3], bcd3(1, 3, 0));
    end
    press(7);
    n_tests++;
    if (dut_vec[14:3] !== bcd3(3, 0, 7)) begin
      n_fail++;
      $display("FAIL key_307: got %h expected %h", dut_vec[14:3], bcd3(3, 0, 7));
    end
    press(4);
    n_tests++;
    if (dut_vec[14:3] !== bcd3(3, 0, 7)) begin
      n_fail++;
      $display("FAIL key_units_gt5_ignored: got %h expected %h", dut_vec[14:3], bcd3(3, 0, 7));
    end
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
    press(10);
    n_tests++;
    if (dut_vec !== 15'd0 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL key_gt9_ignored: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_countdown();
    int hi;
    press(2);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (bus.mag_on !== 1'b1 || dut_vec[14:3] !== bcd3(0, 0, 2)) begin
      n_fail++;
      $display("FAIL cook_start: got %h expected mag=1 time 002", dut_vec);
    end
    idle_cycles(3);
    n_tests++;
    if (dut_vec[14:3] !== bcd3(0, 0, 2)) begin
      n_fail++;
      $display("FAIL cook_no_early_dec: got %h expected %h", dut_vec[14:3], bcd3(0, 0, 2));
    end
    idle_cycles(1);
    n_tests++;
    if (dut_vec[14:3] !== bcd3(0, 0, 1) || bus.mag_on !== 1'b1) begin
      n_fail++;
      $display("FAIL cook_first_dec: got %h expected time 001 mag=1", dut_vec);
    end
    idle_cycles(4);
    n_tests++;
    if (dut_vec[14:3] !== 12'd0 || bus.done !== 1'b1 || bus.mag_on !== 1'b0) begin
      n_fail++;
      $display("FAIL cook_complete: got %h expected time 000 done=1 mag=0", dut_vec);
    end
`ifdef DONE_ALARM_EN
    hi = 0;
    for (int i = 0; i < 30 && bus.alarm === 1'b1; i++) begin
      hi++;
      idle_cycles(1);
    end
    n_tests++;
    if (hi != 12 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL alarm_length: got %0d cycles done=%b expected 12 cycles done=1", hi, bus.done);
    end
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
    n_tests++;
    if (bus.done !== 1'b0 || bus.alarm !== 1'b0 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL done_stop_clear: got %h expected %h", dut_vec, model_vec());
    end
`else
    hi = 0;
    idle_cycles(1);
    n_tests++;
    if (bus.done !== 1'b0 || bus.alarm !== 1'b0 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL done_pulse: got %h expected %h", dut_vec, model_vec());
    end
`endif
  endtask

  task automatic test_double_borrow_pause();
    press(1); press(0); press(0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    idle_cycles(4);
    n_tests++;
    if (dut_vec[14:3] !== bcd3(0, 5, 9)) begin
      n_fail++;
      $display("FAIL double_borrow: got %h expected %h", dut_vec[14:3], bcd3(0, 5, 9));
    end
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (bus.mag_on !== 1'b0 || dut_vec[14:3] !== bcd3(0, 5, 9)) begin
      n_fail++;
      $display("FAIL door_pause: got %h expected mag=0 time 059", dut_vec);
    end
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (bus.mag_on !== 1'b1 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL resume: got %h expected %h", dut_vec, model_vec());
    end
    idle_cycles(5);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (dut_vec !== 15'd0 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL pause_stop_clear: got %h expected %h", dut_vec, 15'd0);
    end
  endtask

  task automatic test_start_stop_same_cycle();
    press(5);
    cycle(1'b0, 0, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (dut_vec !== 15'd0) begin
      n_fail++;
      $display("FAIL start_with_clear: got %h expected %h", dut_vec, 15'd0);
    end
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (dut_vec !== 15'd0 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL start_at_zero: got %h expected %h", dut_vec, 15'd0);
    end
  endtask

  task automatic test_reset_mid_cook();
    press(3); press(0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    idle_cycles(2);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (dut_vec !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_mid_cook: got %h expected %h", dut_vec, 15'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle_cycles(1);
    n_tests++;
    if (dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL after_reset: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_random();
    logic kv, st, sc, dc;
    int   kd;
    for (int i = 0; i < 2000; i++) begin
      kv = ($urandom_range(0, 2) == 0);
      kd = int'($urandom_range(0, 11));
      st = ($urandom_range(0, 3) == 0);
      sc = ($urandom_range(0, 39) == 0);
      dc = ($urandom_range(0, 11) != 0);
      cycle(kv, kd, st, sc, dc);
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_keypad_entry();
    test_countdown();
    test_double_borrow_pause();
    test_start_stop_same_cycle();
    test_reset_mid_cook();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_microwave_timer_ctrl
`default_nettype wire

// File: doc/microwave_timer_ctrl.md
# microwave_timer_ctrl

Sequencing controller for the microwave cook timer. Accepts keypad digits to set a time up to 9:59, counts it down once per second while cooking, and handles door-open pause, stop/clear and completion. Its three BCD digit outputs feed the existing `decoder` (`minutes`, `second_tens`, `second_units`). `mag_on` drives the magnetron enable.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per counted second. Minimum 2.
- `ALARM_SECS`, default 3: seconds the alarm is held. Used only with `DONE_ALARM_EN`.

Ports:
- `clk` input 1: single clock domain.
- `reset` input 1: asynchronous, active-high reset.
- `keypad_valid` input 1: one-cycle strobe; `keypad_digit` is valid in that cycle.
- `keypad_digit` input 4: BCD key value.
- `start` input 1: level-sampled each cycle. A request is acted on in any cycle it is high.
- `stop_clear` input 1: level-sampled each cycle.
- `door_closed` input 1: 1 means the door is closed.
- `minutes` output 4: BCD minutes, 0–9.
- `second_tens` output 4: BCD tens of seconds, 0–5.
- `second_units` output 4: BCD seconds, 0–9.
- `mag_on` output 1: magnetron enable.
- `done` output 1: cook complete indicator.
- `alarm` output 1: buzzer enable. Tied 0 without `DONE_ALARM_EN`.

## Operation
- States: IDLE, COOK, PAUSE, DONE.
- Reset values: state IDLE, all digits 0, prescaler 0, `mag_on` 0, `done` 0, `alarm` 0.

IDLE (time entry):
- On `keypad_valid` with `keypad_digit` ≤ 9 and current `second_units` ≤ 5, the digits shift left:
  - `minutes` ← `second_tens`
  - `second_tens` ← `second_units`
  - `second_units` ← key
- Keys > 9, or keys arriving while `second_units` > 5, are ignored and all digits are held.
- `stop_clear` clears all digits to 0.
- `start` with `door_closed` = 1 and a nonzero time moves to COOK and clears the prescaler. `start` with time 0:00 or the door open is ignored.

COOK:
- `mag_on` = 1.
- The prescaler counts 0 to `TICKS_PER_SEC`−1. On wrap, the time decrements by one BCD second:
  - units 0 → 9 with a borrow from tens.
  - tens 0 → 5 with a borrow from minutes.
- A decrement that produces 0:00 enters DONE on the same edge.
- `door_closed` = 0 or `stop_clear` moves to PAUSE. The prescaler holds its value and the time is not decremented in that cycle.
- Keypad input is ignored.

PAUSE:
- `mag_on` = 0.
- `start` with `door_closed` = 1 returns to COOK, and the prescaler resumes from its held value.
- `stop_clear` moves to IDLE with digits cleared.
- Keypad input is ignored.

DONE:
- `done` = 1, `mag_on` = 0, digits read 0:00.
- The exit behaviour depends on `DONE_ALARM_EN` (see Configuration).

Priority within a single cycle: `reset` > `stop_clear` > door open > `start` > prescaler tick > keypad.

## Timing
- All outputs are registered and change only on the `clk` rising edge or on `reset`.
- `start` sampled at edge N: state is COOK and `mag_on` = 1 after edge N.
- The first decrement occurs `TICKS_PER_SEC` cycles after COOK entry.
- A keypad shift is visible on the digits on the edge after the strobe, so latency is 1 cycle.
- Door opening while in COOK: `mag_on` deasserts on the next edge, so latency is 1 cycle.
- Final decrement to 0:00: `mag_on` falls and `done` rises on the same edge.
- Reset asserted mid-cook returns everything to the reset values immediately, without waiting for a clock edge.

## Configuration
`DONE_ALARM_EN`:
- Defined:
  - DONE persists.
  - `alarm` = 1 for `ALARM_SECS` seconds counted by the prescaler, then falls while `done` stays 1.
  - `stop_clear` or door open moves to IDLE and clears `done` and `alarm`.
  - `start` in DONE is ignored.
- Undefined:
  - `alarm` is tied to 0.
  - DONE lasts one cycle: `done` is a single-cycle pulse, then the block returns to IDLE automatically.

## Structure
- Package `microwave_pkg` holds:
  - the state enum `timer_state_t` (IDLE, COOK, PAUSE, DONE);
  - the `bcd_digit_t` 4-bit typedef;
  - constants `MAX_MINUTES` = 9, `MAX_TENS` = 5, `MAX_UNITS` = 9.
- Sub-module `bcd_time_counter` contains the three digit registers. It has:
  - a `shift_in` port (key entry);
  - a `dec` port (one-second decrement);
  - a `clear` port;
  - an `is_zero` flag output.
- The FSM and prescaler stay in the top module.

## Test plan
Run with `TICKS_PER_SEC` = 4.
- Keys 1, 3, 0 then key 7 → digits 1:30, then 3:07. With digits at x:x7, key 4 → ignored, digits unchanged.
- Load 0:02, door closed, `start` → `mag_on` = 1; 0:01 after 4 cycles; 0:00 and `done` = 1 after 8 cycles, with `mag_on` = 0 on that same edge.
- Load 1:00, cook 4 cycles → 0:59 (double borrow). Open door → PAUSE with `mag_on` = 0. Close door, `start` → resumes. `stop_clear` in PAUSE → IDLE at 0:00.
- `start` and `stop_clear` in the same cycle while in IDLE at 0:05 → digits cleared, stays IDLE. `start` at 0:00 → stays IDLE.
- With `DONE_ALARM_EN` and `ALARM_SECS` = 3: after completion, `alarm` is high for 12 cycles and then falls while `done` stays high; `stop_clear` → IDLE. Without the macro: `done` is high for exactly 1 cycle.
- `reset` pulse mid-COOK → all outputs 0 immediately.
